// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed hex display driver with dead-time scanning,
// leading-zero blanking and tear-free frame-boundary value swaps.
module seven_seg_scan #(
   parameter int DIGITS         = 4,
   parameter int PRESCALE       = 12000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [4*DIGITS-1:0]   value_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  load,
   input  logic                  blank_lz,
   input  logic                  enable,
   output logic [7:0]            seg_out,
   output logic [DIGITS-1:0]     an_out,
   output logic                  frame_done
);
   localparam int CW = $clog2(PRESCALE);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW != 0 ? '1 : '0;
   localparam logic [6:0] DECODE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0] disp_val_q, disp_val_d, pend_val_q, pend_val_d;
   logic [DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
   logic                pend_valid_q, pend_valid_d;
   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                fd_q, fd_d;
   logic                slot_end, wrap, blank;
   logic [3:0]          nib;
   logic [DIGITS-1:0]   allz, dp_sh, blank_sh, oh;
   logic [7:0]          seg_hi;

   always_comb begin
      slot_end     = enable && cnt_q == CW'(PRESCALE - 1);
      wrap         = slot_end && idx_q == IW'(DIGITS - 1);
      cnt_d        = enable ? (slot_end ? '0 : cnt_q + 1'b1) : cnt_q;
      idx_d        = slot_end ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
      pend_val_d   = load ? value_in : pend_val_q;
      pend_dp_d    = load ? dp_in : pend_dp_q;
      // a load on the wrap cycle keeps pending alive for the next frame
      pend_valid_d = load || (pend_valid_q && !wrap);
      disp_val_d   = wrap && pend_valid_q ? pend_val_q : disp_val_q;
      disp_dp_d    = wrap && pend_valid_q ? pend_dp_q : disp_dp_q;
      allz         = '0;
      for (int i = 0; i < DIGITS; i++) allz[i] = (disp_val_q >> (4 * i)) == '0;
      nib          = 4'(disp_val_q >> {idx_q, 2'b00});
      dp_sh        = disp_dp_q >> idx_q;
      blank_sh     = allz >> idx_q;
      blank        = blank_lz && idx_q != '0 && blank_sh[0] && !dp_sh[0];
      seg_hi       = {dp_sh[0], blank ? 7'h00 : DECODE[nib]};
      oh           = DIGITS'(1) << idx_q;
      seg_d        = enable ? (SEG_ACTIVE_LOW != 0 ? ~seg_hi : seg_hi) : SEG_OFF;
      an_d         = enable && cnt_q != '0 ? (AN_ACTIVE_LOW != 0 ? ~oh : oh) : AN_OFF;
      fd_d         = wrap;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_valid_q <= 1'b0;
         seg_q        <= SEG_OFF;
         an_q         <= AN_OFF;
         fd_q         <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_valid_q <= pend_valid_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         fd_q         <= fd_d;
      end
   end

   assign seg_out    = seg_q;
   assign an_out     = an_q;
   assign frame_done = fd_q;
endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Parametrised, time-multiplexed hex display driver for a bank of DIGITS common-anode seven-segment digits.
- Holds a DIGITS-nibble value and per-digit decimal points.
- Scans one digit at a time at a prescaled rate, with dead time between digits to suppress ghosting.
- Applies optional leading-zero blanking.
- Swaps in newly loaded values only on frame boundaries, so the display never tears.
- Sits between user logic (counters, debug registers) and the board's shared segment and anode pins.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8); index 0 is the rightmost (least significant) digit.
PRESCALE, 12000, clock cycles per digit slot (>=2).
SEG_ACTIVE_LOW, 1, 1: seg_out bit is 0 when a segment is lit; 0: active-high.
AN_ACTIVE_LOW, 1, 1: an_out bit is 0 when a digit is enabled; 0: active-high.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous reset, active-low
value_in  in  4*DIGITS  hex value; nibble i drives digit i
dp_in  in  DIGITS  decimal point request per digit
load  in  1  1-cycle strobe; captures value_in/dp_in into the pending register
blank_lz  in  1  1: blank leading zero digits
enable  in  1  0: display dark, scan frozen
seg_out  out  8  bit7=dp, bits6..0 = g,f,e,d,c,b,a
an_out  out  DIGITS  one-hot digit enable
frame_done  out  1  1-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0

Behaviour:
- Reset (resetn=0 at a clk edge):
  - Prescale counter cnt=0, digit index idx=0.
  - Display and pending registers are all zero; pending_valid=0.
  - seg_out and an_out are all "off" per their polarity: 8'hFF and all-ones when active-low.
  - frame_done=0.
  - Reset mid-scan aborts immediately; there is no partial-frame completion.
- Prescaler:
  - When enable=1, cnt counts 0..PRESCALE-1 and then wraps.
  - When cnt==PRESCALE-1, idx advances to (idx+1) mod DIGITS.
  - When idx wraps DIGITS-1 -> 0, frame_done pulses on the following cycle.
- Load and frame swap:
  - On load=1, value_in/dp_in are captured into the pending register and pending_valid=1. A second load before the swap overwrites the pending register; last one wins.
  - At the wrap edge, if pending_valid was set before that cycle, pending is copied to the display register and pending_valid is cleared.
  - A load on the wrap cycle itself is held for the next wrap.
  - The display register never changes mid-frame.
- Outputs (registered, 1 cycle latency from cnt/idx):
  - an_out: all off when cnt==0 (dead slot), otherwise one-hot idx.
  - seg_out: the decode of display nibble idx, plus dp.
- Decode, active-high gfedcba:
  - 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
  - dp bit = display dp[idx].
  - Inverted when SEG_ACTIVE_LOW=1, so 0 without dp gives 8'b11000000 and 1 gives 8'b11111001.
- Leading-zero blanking:
  - When blank_lz=1, digit i>0 is blanked (all segments off, an_out still asserted) if display nibbles i..DIGITS-1 are all zero and display dp[i]=0.
  - Digit 0 is never blanked.
  - blank_lz is sampled live, not latched.
- enable=0:
  - cnt and idx hold; seg_out and an_out go off on the next cycle; frame_done=0.
  - Loads are still accepted into pending.
  - Resuming continues from the held cnt/idx.
- DIGITS=1: idx stays 0 and frame_done pulses every PRESCALE cycles.

Test Plan:
- DIGITS=4, PRESCALE=4, both polarities active-low; release reset, load 16'h12AF, dp=0 -> frame 1 displays zeros. From frame 2, digits 0..3 show seg 8'h8E, 8'h88, 8'hA4, 8'hF9; each digit is enabled 3 cycles with 1 dead cycle (an_out=4'hF); frame_done pulses every 16 cycles.
- blank_lz=1, load 16'h0030 -> digits 3,2 have an_out asserted with seg 8'hFF; digit 1 shows 8'hB0; digit 0 shows 8'hC0. Then set dp_in=4'b0100 and load -> digit 2 shows 8'h40.
- Load 16'h1111 then load 16'h2222 mid-frame, with the display showing 16'h0000 until the wrap -> no digit shows 1. From the next frame all digits show 8'hA4.
- Load asserted exactly on the wrap cycle -> the old pending value is applied (or none if pending_valid=0); the new value appears one frame later.
- enable low for 10 cycles mid-slot -> an_out=4'hF and seg_out=8'hFF for the duration; cnt/idx are unchanged; the scan resumes at the same digit and count.
- resetn low for 1 cycle mid-frame -> next cycle: outputs off, idx=0, display cleared, pending dropped, no frame_done pulse.
